// File: rtl/telemetry_collector_mc.sv
// telemetry_collector_mc: merges NUM_CH receiver word streams and a PPS-latched
// status snapshot onto one transmit port (TR_IN strobe with ADDR_IN/DATA_IN).
// Latency: 4 cycles from CH_VALID to TR_IN when idle; at most one word every 4 cycles.
// Backpressure: TR_IN_BUSY holds the word in WAIT; full FIFOs drop words and set DROP_FLAG.
//
// Ports:
//   TR_CLK, RESET_N          clock and asynchronous active-low reset
//   CH_VALID/CH_ADDR/CH_DATA per-channel write port, one word per cycle per channel
//   CH_FULL, DROP_FLAG       per-channel FIFO full and sticky drop indication
//   CLR_FLAGS                synchronous clear of DROP_FLAG and SNAP_MISSED
//   PPS_IN, SNAP_DATA        asynchronous 1PPS and the status words it latches
//   TR_IN/ADDR_IN/DATA_IN    transmit strobe, address and data
//   TR_IN_BUSY               downstream busy, no strobe while high
//   SNAP_ACTIVE, SNAP_MISSED burst in progress, sticky missed PPS edge

// Small synchronous FIFO used once per channel.
// Latency: read data is the head entry, visible combinationally one cycle after push.
// Backpressure: caller must not push when full_o or pop when empty_o.
module telemetry_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdat_i,
   output logic [W-1:0] rdat_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= wdat_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign rdat_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
endmodule

module telemetry_collector_mc #(
   parameter int NUM_CH        = 4,
   parameter int FIFO_DEPTH    = 16,
   parameter int NUM_REGS      = 21,
   parameter int SNAP_BASE     = 300,
   parameter int SNAP_PRIORITY = 1
) (
   input  logic                   TR_CLK,
   input  logic                   RESET_N,
   input  logic [NUM_CH-1:0]      CH_VALID,
   input  logic [16*NUM_CH-1:0]   CH_ADDR,
   input  logic [32*NUM_CH-1:0]   CH_DATA,
   output logic [NUM_CH-1:0]      CH_FULL,
   output logic [NUM_CH-1:0]      DROP_FLAG,
   input  logic                   CLR_FLAGS,
   input  logic                   PPS_IN,
   input  logic [32*NUM_REGS-1:0] SNAP_DATA,
   output logic                   TR_IN,
   output logic [15:0]            ADDR_IN,
   output logic [31:0]            DATA_IN,
   input  logic                   TR_IN_BUSY,
   output logic                   SNAP_ACTIVE,
   output logic                   SNAP_MISSED
);
   localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int          IDX_W       = $clog2(NUM_REGS + 1);
   localparam logic [15:0] SNAP_BASE_W = 16'(SNAP_BASE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STROBE
   } state_t;

   state_t state_q, state_d;

   // Channel FIFOs
   logic [NUM_CH-1:0] fifo_push;
   logic [NUM_CH-1:0] fifo_pop;
   logic [NUM_CH-1:0] fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [47:0]       fifo_rdat [NUM_CH];

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      // Full is judged on the registered count, so a word offered to a full
      // FIFO is dropped even if the same cycle pops it.
      assign fifo_push[n] = CH_VALID[n] & ~fifo_full[n];

      telemetry_fifo #(
         .W     (48),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (TR_CLK),
         .rst_n_i (RESET_N),
         .push_i  (fifo_push[n]),
         .pop_i   (fifo_pop[n]),
         .wdat_i  ({CH_ADDR[16*n +: 16], CH_DATA[32*n +: 32]}),
         .rdat_o  (fifo_rdat[n]),
         .full_o  (fifo_full[n]),
         .empty_o (fifo_empty[n])
      );
   end

   // PPS synchroniser and rising-edge detect
   logic pps_meta_q, pps_sync_q, pps_dly_q;
   logic pps_edge;

   always_ff @(posedge TR_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pps_meta_q <= 1'b0;
         pps_sync_q <= 1'b0;
         pps_dly_q  <= 1'b0;
      end else begin
         pps_meta_q <= PPS_IN;
         pps_sync_q <= pps_meta_q;
         pps_dly_q  <= pps_sync_q;
      end
   end

   assign pps_edge = pps_sync_q & ~pps_dly_q;

   // Datapath and control state
   logic              tr_q, tr_d;
   logic [15:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              snap_active_q, snap_active_d;
   logic              snap_pending_q, snap_pending_d;
   logic              snap_missed_q, snap_missed_d;
   logic [NUM_CH-1:0] drop_q, drop_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [47:0]       word_q, word_d;
   logic [31:0]       bank_q [NUM_REGS];

   // A new edge is only accepted when no burst is queued or running, so the
   // bank always holds the values of the burst being sent.
   logic snap_take;
   logic missed_evt;

   assign snap_take  = pps_edge & ~snap_pending_q & ~snap_active_q;
   assign missed_evt = pps_edge & (snap_pending_q | snap_active_q);

   always_ff @(posedge TR_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      end else if (snap_take) begin
         for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= SNAP_DATA[32*i +: 32];
      end
   end

   // Round-robin search: first non-empty channel at or above rr_q, wrapping.
   logic              ch_found;
   logic [NUM_CH-1:0] ch_sel_oh;
   logic [47:0]       ch_sel_word;
   logic [CH_W-1:0]   rr_next;
   int                scan_c;

   always_comb begin
      ch_found    = 1'b0;
      ch_sel_oh   = '0;
      ch_sel_word = '0;
      rr_next     = rr_q;
      scan_c      = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_c = (int'(rr_q) + k) % NUM_CH;
         if (!ch_found && !fifo_empty[scan_c]) begin
            ch_found          = 1'b1;
            ch_sel_oh[scan_c] = 1'b1;
            ch_sel_word       = fifo_rdat[scan_c];
            rr_next           = CH_W'((scan_c + 1) % NUM_CH);
         end
      end
   end

   logic [31:0] snap_word;

   always_comb begin
      snap_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx_q == IDX_W'(i)) snap_word = bank_q[i];
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d        = state_q;
      tr_d           = tr_q;
      addr_d         = addr_q;
      data_d         = data_q;
      snap_active_d  = snap_active_q;
      snap_pending_d = snap_pending_q | snap_take;
      idx_d          = idx_q;
      rr_d           = rr_q;
      word_d         = word_q;
      fifo_pop       = '0;
      // Set wins over a coincident clear.
      drop_d         = (drop_q & ~{NUM_CH{CLR_FLAGS}}) | (CH_VALID & fifo_full);
      snap_missed_d  = (snap_missed_q & ~CLR_FLAGS) | missed_evt;

      case (state_q)
         S_IDLE: begin
            if (snap_active_q) begin
               // Mid-burst: channels wait until the last word has gone out.
               state_d = S_LOAD;
            end else if (snap_pending_q && (SNAP_PRIORITY != 0 || (&fifo_empty))) begin
               snap_active_d  = 1'b1;
               snap_pending_d = 1'b0;
               idx_d          = '0;
               state_d        = S_LOAD;
            end else if (ch_found) begin
               fifo_pop = ch_sel_oh;
               word_d   = ch_sel_word;
               rr_d     = rr_next;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            // snap_active_q cannot change between IDLE and here, so it tells
            // which source the current word came from.
            if (snap_active_q) begin
               addr_d = SNAP_BASE_W + 16'(idx_q);
               data_d = snap_word;
               idx_d  = idx_q + 1'b1;
            end else begin
               addr_d = word_q[47:32];
               data_d = word_q[31:0];
            end
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!TR_IN_BUSY) begin
               tr_d    = 1'b1;
               state_d = S_STROBE;
            end
         end
         S_STROBE: begin
            tr_d = 1'b0;
            if (snap_active_q && idx_q == IDX_W'(NUM_REGS)) snap_active_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge TR_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q        <= S_IDLE;
         tr_q           <= 1'b0;
         addr_q         <= '0;
         data_q         <= '0;
         snap_active_q  <= 1'b0;
         snap_pending_q <= 1'b0;
         snap_missed_q  <= 1'b0;
         drop_q         <= '0;
         idx_q          <= '0;
         rr_q           <= '0;
         word_q         <= '0;
      end else begin
         state_q        <= state_d;
         tr_q           <= tr_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         snap_active_q  <= snap_active_d;
         snap_pending_q <= snap_pending_d;
         snap_missed_q  <= snap_missed_d;
         drop_q         <= drop_d;
         idx_q          <= idx_d;
         rr_q           <= rr_d;
         word_q         <= word_d;
      end
   end

   assign CH_FULL     = fifo_full;
   assign DROP_FLAG   = drop_q;
   assign TR_IN       = tr_q;
   assign ADDR_IN     = addr_q;
   assign DATA_IN     = data_q;
   assign SNAP_ACTIVE = snap_active_q;
   assign SNAP_MISSED = snap_missed_q;
endmodule

// File: tb/tb_telemetry_collector_mc.sv
module tb_telemetry_collector_mc;
   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int NUM_REGS   = 21;
   localparam int SNAP_BASE  = 300;

   logic                   TR_CLK = 1'b0;
   logic                   RESET_N;
   logic [NUM_CH-1:0]      CH_VALID;
   logic [16*NUM_CH-1:0]   CH_ADDR;
   logic [32*NUM_CH-1:0]   CH_DATA;
   logic [NUM_CH-1:0]      CH_FULL;
   logic [NUM_CH-1:0]      DROP_FLAG;
   logic                   CLR_FLAGS;
   logic                   PPS_IN;
   logic [32*NUM_REGS-1:0] SNAP_DATA;
   logic                   TR_IN;
   logic [15:0]            ADDR_IN;
   logic [31:0]            DATA_IN;
   logic                   TR_IN_BUSY;
   logic                   SNAP_ACTIVE;
   logic                   SNAP_MISSED;

   telemetry_collector_mc #(
      .NUM_CH        (NUM_CH),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .NUM_REGS      (NUM_REGS),
      .SNAP_BASE     (SNAP_BASE),
      .SNAP_PRIORITY (1)
   ) dut (
      .TR_CLK      (TR_CLK),
      .RESET_N     (RESET_N),
      .CH_VALID    (CH_VALID),
      .CH_ADDR     (CH_ADDR),
      .CH_DATA     (CH_DATA),
      .CH_FULL     (CH_FULL),
      .DROP_FLAG   (DROP_FLAG),
      .CLR_FLAGS   (CLR_FLAGS),
      .PPS_IN      (PPS_IN),
      .SNAP_DATA   (SNAP_DATA),
      .TR_IN       (TR_IN),
      .ADDR_IN     (ADDR_IN),
      .DATA_IN     (DATA_IN),
      .TR_IN_BUSY  (TR_IN_BUSY),
      .SNAP_ACTIVE (SNAP_ACTIVE),
      .SNAP_MISSED (SNAP_MISSED)
   );

   always #5 TR_CLK = ~TR_CLK;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic        snap;
   } exp_t;

   typedef struct {
      int          ch;
      logic [15:0] addr;
      logic [31:0] data;
      int          exp_lat;
   } vec_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   strobe_cnt = 0;
   logic tr_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every strobe must match the oldest expected word.
   always @(negedge TR_CLK) begin
      if (TR_IN === 1'b1) begin
         exp_t e;
         strobe_cnt++;
         check("tr_single_cycle", 64'(tr_prev), 64'd0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got ADDR_IN=0x%0h DATA_IN=0x%0h, expected no strobe",
                     ADDR_IN, DATA_IN);
         end else begin
            e = sb.pop_front();
            check("strobe_addr", 64'(ADDR_IN), 64'(e.addr));
            check("strobe_data", 64'(DATA_IN), 64'(e.data));
            check("strobe_snap_active", 64'(SNAP_ACTIVE), 64'(e.snap));
         end
      end
      tr_prev = TR_IN;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge TR_CLK);
      #1;
   endtask

   task automatic push_exp(input logic [15:0] a, input logic [31:0] d, input logic s);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.snap = s;
      sb.push_back(e);
   endtask

   task automatic write_word(input int ch, input logic [15:0] a, input logic [31:0] d);
      CH_VALID = '0;
      CH_VALID[ch] = 1'b1;
      CH_ADDR[16*ch +: 16] = a;
      CH_DATA[32*ch +: 32] = d;
      tick(1);
      CH_VALID = '0;
   endtask

   // Returns the number of edges waited until TR_IN is seen high, -1 on timeout.
   task automatic wait_strobe(input int max, output int n);
      n = -1;
      for (int k = 1; k <= max; k++) begin
         @(posedge TR_CLK);
         #1;
         if (TR_IN === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic drain(input string name, input int max);
      for (int k = 0; k < max; k++) begin
         if (sb.size() == 0) break;
         tick(1);
      end
      tick(3);
      check(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic pulse_pps();
      PPS_IN = 1'b1;
      tick(3);
      PPS_IN = 1'b0;
   endtask

   task automatic set_snap(input logic [31:0] base, input logic [31:0] step, input logic inv);
      for (int i = 0; i < NUM_REGS; i++)
         SNAP_DATA[32*i +: 32] = inv ? ~(base + 32'(i) * step) : (base + 32'(i) * step);
   endtask

   task automatic do_reset();
      RESET_N    = 1'b0;
      sb.delete();
      CH_VALID   = '0;
      CLR_FLAGS  = 1'b0;
      PPS_IN     = 1'b0;
      TR_IN_BUSY = 1'b0;
      tick(2);
      RESET_N = 1'b1;
      tick(1);
   endtask

   vec_t vecs[5];
   int   n;
   int   base_cnt;

   initial begin
      vecs[0] = '{0, 16'h0012, 32'hDEADBEEF, 4};
      vecs[1] = '{3, 16'hABCD, 32'h12345678, 4};
      vecs[2] = '{1, 16'hFFFF, 32'h00000000, 4};
      vecs[3] = '{2, 16'h0000, 32'hFFFFFFFF, 4};
      vecs[4] = '{0, 16'h8001, 32'hA5A5A5A5, 4};

      RESET_N    = 1'b0;
      CH_VALID   = '0;
      CH_ADDR    = '0;
      CH_DATA    = '0;
      CLR_FLAGS  = 1'b0;
      PPS_IN     = 1'b0;
      SNAP_DATA  = '0;
      TR_IN_BUSY = 1'b0;

      // Reset state
      #12;
      check("rst_tr_in", 64'(TR_IN), 64'd0);
      check("rst_addr_in", 64'(ADDR_IN), 64'd0);
      check("rst_data_in", 64'(DATA_IN), 64'd0);
      check("rst_snap_active", 64'(SNAP_ACTIVE), 64'd0);
      check("rst_snap_missed", 64'(SNAP_MISSED), 64'd0);
      check("rst_drop_flag", 64'(DROP_FLAG), 64'd0);
      check("rst_ch_full", 64'(CH_FULL), 64'd0);
      @(posedge TR_CLK);
      #1;
      RESET_N = 1'b1;
      tick(1);

      // Single words from an idle collector: latency and hold of ADDR/DATA
      foreach (vecs[i]) begin
         push_exp(vecs[i].addr, vecs[i].data, 1'b0);
         write_word(vecs[i].ch, vecs[i].addr, vecs[i].data);
         wait_strobe(20, n);
         check("single_latency", 64'(n + 1), 64'(vecs[i].exp_lat));
         tick(3);
         check("single_addr_hold", 64'(ADDR_IN), 64'(vecs[i].addr));
         check("single_data_hold", 64'(DATA_IN), 64'(vecs[i].data));
      end
      check("single_sb_empty", 64'(sb.size()), 64'd0);

      // Round robin over four channels with two words each
      do_reset();
      TR_IN_BUSY = 1'b1;
      for (int w = 0; w < 2; w++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            CH_VALID[c] = 1'b1;
            CH_ADDR[16*c +: 16] = 16'h0100 + 16'(16 * w + c);
            CH_DATA[32*c +: 32] = 32'hC0DE0000 + 32'(256 * w + c);
            push_exp(16'h0100 + 16'(16 * w + c), 32'hC0DE0000 + 32'(256 * w + c), 1'b0);
         end
         tick(1);
      end
      CH_VALID = '0;
      tick(5);
      TR_IN_BUSY = 1'b0;
      wait_strobe(20, n);
      check("rr_first_found", 64'(n > 0), 64'd1);
      for (int i = 1; i < 8; i++) begin
         wait_strobe(20, n);
         check("rr_interval", 64'(n), 64'd4);
      end
      drain("rr_sb_empty", 50);

      // Overflow of channel 1 while the FSM is stalled on a channel 0 word
      do_reset();
      TR_IN_BUSY = 1'b1;
      push_exp(16'h0077, 32'h77777777, 1'b0);
      write_word(0, 16'h0077, 32'h77777777);
      tick(4);
      for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
         if (i < FIFO_DEPTH) push_exp(16'h0200 + 16'(i), 32'h500 + 32'(3 * i), 1'b0);
         write_word(1, 16'h0200 + 16'(i), 32'h500 + 32'(3 * i));
      end
      check("ovf_ch_full", 64'(CH_FULL), 64'b0010);
      check("ovf_drop_flag", 64'(DROP_FLAG), 64'b0010);
      CLR_FLAGS = 1'b1;
      write_word(1, 16'hDEAD, 32'hDEADDEAD);
      CLR_FLAGS = 1'b0;
      check("ovf_clr_vs_drop", 64'(DROP_FLAG), 64'b0010);
      base_cnt = strobe_cnt;
      TR_IN_BUSY = 1'b0;
      drain("ovf_sb_empty", 200);
      check("ovf_strobe_count", 64'(strobe_cnt - base_cnt), 64'(FIFO_DEPTH + 1));
      check("ovf_full_after", 64'(CH_FULL), 64'd0);
      check("ovf_drop_sticky", 64'(DROP_FLAG), 64'b0010);
      CLR_FLAGS = 1'b1;
      tick(1);
      CLR_FLAGS = 1'b0;
      check("ovf_drop_cleared", 64'(DROP_FLAG), 64'd0);

      // Snapshot burst takes priority over pending channel 2 data
      do_reset();
      set_snap(32'h0, 32'h11, 1'b0);
      TR_IN_BUSY = 1'b1;
      push_exp(16'h0001, 32'h11111111, 1'b0);
      write_word(0, 16'h0001, 32'h11111111);
      tick(3);
      write_word(2, 16'h0222, 32'h22222222);
      pulse_pps();
      tick(4);
      check("burst_not_yet_active", 64'(SNAP_ACTIVE), 64'd0);
      for (int i = 0; i < NUM_REGS; i++)
         push_exp(16'(SNAP_BASE + i), 32'(i * 32'h11), 1'b1);
      push_exp(16'h0222, 32'h22222222, 1'b0);
      base_cnt = strobe_cnt;
      TR_IN_BUSY = 1'b0;
      drain("burst_sb_empty", 300);
      check("burst_strobe_count", 64'(strobe_cnt - base_cnt), 64'(NUM_REGS + 2));
      check("burst_active_after", 64'(SNAP_ACTIVE), 64'd0);
      check("burst_no_miss", 64'(SNAP_MISSED), 64'd0);

      // Second PPS during a stalled burst: missed, bank keeps first values
      do_reset();
      set_snap(32'h1000, 32'h1, 1'b0);
      TR_IN_BUSY = 1'b1;
      pulse_pps();
      tick(6);
      check("miss_burst_active", 64'(SNAP_ACTIVE), 64'd1);
      for (int i = 0; i < NUM_REGS; i++)
         push_exp(16'(SNAP_BASE + i), 32'h1000 + 32'(i), 1'b1);
      set_snap(32'h1000, 32'h1, 1'b1);
      pulse_pps();
      tick(5);
      check("miss_flag_set", 64'(SNAP_MISSED), 64'd1);
      TR_IN_BUSY = 1'b0;
      drain("miss_sb_empty", 300);
      check("miss_active_after", 64'(SNAP_ACTIVE), 64'd0);
      check("miss_flag_sticky", 64'(SNAP_MISSED), 64'd1);
      CLR_FLAGS = 1'b1;
      tick(1);
      CLR_FLAGS = 1'b0;
      check("miss_flag_cleared", 64'(SNAP_MISSED), 64'd0);

      // Reset while a burst waits on busy, with channel data queued
      do_reset();
      set_snap(32'h2000, 32'h3, 1'b0);
      TR_IN_BUSY = 1'b1;
      pulse_pps();
      tick(6);
      write_word(3, 16'h0333, 32'h33333333);
      tick(2);
      check("rst_mid_active_before", 64'(SNAP_ACTIVE), 64'd1);
      #2;
      RESET_N = 1'b0;
      #1;
      sb.delete();
      check("rst_mid_tr_in", 64'(TR_IN), 64'd0);
      check("rst_mid_snap_active", 64'(SNAP_ACTIVE), 64'd0);
      check("rst_mid_addr_in", 64'(ADDR_IN), 64'd0);
      tick(2);
      RESET_N = 1'b1;
      TR_IN_BUSY = 1'b0;
      base_cnt = strobe_cnt;
      tick(30);
      check("rst_mid_no_strobe", 64'(strobe_cnt - base_cnt), 64'd0);
      check("rst_mid_ch_full", 64'(CH_FULL), 64'd0);
      push_exp(16'h0444, 32'h44444444, 1'b0);
      write_word(1, 16'h0444, 32'h44444444);
      wait_strobe(20, n);
      check("rst_mid_new_latency", 64'(n + 1), 64'd4);
      drain("rst_mid_sb_empty", 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
